// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control path: state encodings,
// opcodes, ALUOp codes and datapath selector values. Also used by
// ALU_Control and the datapath.
package mips_ctrl_pkg;

  // FSM state encodings (10-15 unused)
  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;

  // instruction[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUOp as consumed by ALU_Control
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] ALUSRCB_B       = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Datapath control bundle driven each cycle
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
  } ctrl_t;

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state function of the multi-cycle control FSM.
// Flags an unsupported opcode when it is seen in DECODE.
module mc_next_state
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state_i,
  input  logic [5:0]         opcode_i,
  input  logic               ready_i,
  output logic [STATE_W-1:0] next_o,
  output logic               illegal_o
);

  // next state from current state, opcode and effective memory ready
  always_comb begin
    next_o    = STATE_W'(S_FETCH);
    illegal_o = 1'b0;
    case (state_i)
      STATE_W'(S_FETCH):
        next_o = ready_i ? STATE_W'(S_DECODE) : STATE_W'(S_FETCH);
      STATE_W'(S_DECODE): begin
        case (opcode_i)
          OP_LW, OP_SW: next_o = STATE_W'(S_MEM_ADDR);
          OP_RTYPE:     next_o = STATE_W'(S_R_EXEC);
          OP_BEQ:       next_o = STATE_W'(S_BRANCH);
          OP_J:         next_o = STATE_W'(S_JUMP);
          default:      illegal_o = 1'b1;
        endcase
      end
      STATE_W'(S_MEM_ADDR): begin
        // only lw/sw reach here; anything else falls back to FETCH
        if (opcode_i == OP_LW)      next_o = STATE_W'(S_MEM_READ);
        else if (opcode_i == OP_SW) next_o = STATE_W'(S_MEM_WRITE);
      end
      STATE_W'(S_MEM_READ):
        next_o = ready_i ? STATE_W'(S_MEM_WB) : STATE_W'(S_MEM_READ);
      STATE_W'(S_MEM_WRITE):
        next_o = ready_i ? STATE_W'(S_FETCH) : STATE_W'(S_MEM_WRITE);
      STATE_W'(S_R_EXEC):
        next_o = STATE_W'(S_R_WB);
      default:
        next_o = STATE_W'(S_FETCH);
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS-subset datapath. Moore-decoded
// controls, with IRWrite/PCWrite in FETCH qualified by memory ready.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_EN = 1,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUOp,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  logic [STATE_W-1:0] state_q, state_d, state_nx;
  logic               illegal_q, illegal_d, dec_illegal;
  logic               ready;
  ctrl_t              ctl;

  // with waits disabled the memory is treated as single-cycle
  assign ready = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

  mc_next_state #(.STATE_W(STATE_W)) u_ns (
    .state_i   (state_q),
    .opcode_i  (opcode),
    .ready_i   (ready),
    .next_o    (state_nx),
    .illegal_o (dec_illegal)
  );

  // state and sticky illegal-opcode flag
  always_ff @(posedge clk) begin
    state_q   <= state_d;
    illegal_q <= illegal_d;
  end

  // reset overrides every transition
  always_comb begin
    state_d   = rst ? STATE_W'(S_FETCH) : state_nx;
    illegal_d = rst ? 1'b0 : (illegal_q | dec_illegal);
  end

  // Moore output decode; reset forces everything low
  always_comb begin
    ctl = '0;
    if (!rst) begin
      case (state_q)
        STATE_W'(S_FETCH): begin
          ctl.mem_read  = 1'b1;
          ctl.alu_src_b = ALUSRCB_FOUR;
          ctl.alu_op    = ALUOP_ADD;
          ctl.pc_source = PCSRC_ALU;
          ctl.ir_write  = ready;
          ctl.pc_write  = ready;
        end
        STATE_W'(S_DECODE): begin
          // branch target precomputed into ALUOut
          ctl.alu_src_b = ALUSRCB_IMM_SH2;
          ctl.alu_op    = ALUOP_ADD;
        end
        STATE_W'(S_MEM_ADDR): begin
          ctl.alu_src_a = 1'b1;
          ctl.alu_src_b = ALUSRCB_IMM;
          ctl.alu_op    = ALUOP_ADD;
        end
        STATE_W'(S_MEM_READ): begin
          ctl.mem_read = 1'b1;
          ctl.iord     = 1'b1;
        end
        STATE_W'(S_MEM_WB): begin
          ctl.reg_write  = 1'b1;
          ctl.mem_to_reg = 1'b1;
        end
        STATE_W'(S_MEM_WRITE): begin
          // held for the whole wait so memory sees a stable request
          ctl.mem_write = 1'b1;
          ctl.iord      = 1'b1;
        end
        STATE_W'(S_R_EXEC): begin
          ctl.alu_src_a = 1'b1;
          ctl.alu_src_b = ALUSRCB_B;
          ctl.alu_op    = ALUOP_FUNCT;
        end
        STATE_W'(S_R_WB): begin
          ctl.reg_write = 1'b1;
          ctl.reg_dst   = 1'b1;
        end
        STATE_W'(S_BRANCH): begin
          ctl.alu_src_a     = 1'b1;
          ctl.alu_src_b     = ALUSRCB_B;
          ctl.alu_op        = ALUOP_SUB;
          ctl.pc_write_cond = 1'b1;
          ctl.pc_source     = PCSRC_ALUOUT;
        end
        STATE_W'(S_JUMP): begin
          ctl.pc_write  = 1'b1;
          ctl.pc_source = PCSRC_JUMP;
        end
        default: ctl = '0;
      endcase
    end
  end

  assign PCWrite     = ctl.pc_write;
  assign PCWriteCond = ctl.pc_write_cond;
  assign IorD        = ctl.iord;
  assign MemRead     = ctl.mem_read;
  assign MemWrite    = ctl.mem_write;
  assign MemtoReg    = ctl.mem_to_reg;
  assign IRWrite     = ctl.ir_write;
  assign PCSource    = ctl.pc_source;
  assign ALUOp       = ctl.alu_op;
  assign ALUSrcA     = ctl.alu_src_a;
  assign ALUSrcB     = ctl.alu_src_b;
  assign RegWrite    = ctl.reg_write;
  assign RegDst      = ctl.reg_dst;
  assign illegal_op  = illegal_q & ~rst;
  assign state_dbg   = rst ? STATE_W'(S_FETCH) : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Control outputs are packed into a
// 16-bit word {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,
// PCSource,ALUOp,ALUSrcA,ALUSrcB,RegWrite,RegDst} and compared per state.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b1;

  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic ALUSrcA, RegWrite, RegDst, illegal_op;
  logic [3:0] state_dbg;

  logic n_PCWrite, n_PCWriteCond, n_IorD, n_MemRead, n_MemWrite, n_MemtoReg, n_IRWrite;
  logic [1:0] n_PCSource, n_ALUOp, n_ALUSrcB;
  logic n_ALUSrcA, n_RegWrite, n_RegDst, n_illegal_op;
  logic [3:0] n_state_dbg;

  logic [15:0] ctl, ctl_nw;
  int n_cmp = 0;
  int n_err = 0;

  // expected control words
  localparam logic [15:0] C_FETCH   = 16'h9204;
  localparam logic [15:0] C_FETCH_W = 16'h1004;
  localparam logic [15:0] C_DECODE  = 16'h000C;
  localparam logic [15:0] C_MADDR   = 16'h0018;
  localparam logic [15:0] C_MREAD   = 16'h3000;
  localparam logic [15:0] C_MWB     = 16'h0402;
  localparam logic [15:0] C_MWRITE  = 16'h2800;
  localparam logic [15:0] C_REXEC   = 16'h0050;
  localparam logic [15:0] C_RWB     = 16'h0003;
  localparam logic [15:0] C_BRANCH  = 16'h40B0;
  localparam logic [15:0] C_JUMP    = 16'h8100;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_WAIT_EN(1), .STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .PCSource(PCSource),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  // memory treated as always ready; mem_ready tied low
  multicycle_control #(.MEM_WAIT_EN(0), .STATE_W(4)) dut_nw (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(1'b0),
    .PCWrite(n_PCWrite), .PCWriteCond(n_PCWriteCond), .IorD(n_IorD), .MemRead(n_MemRead),
    .MemWrite(n_MemWrite), .MemtoReg(n_MemtoReg), .IRWrite(n_IRWrite), .PCSource(n_PCSource),
    .ALUOp(n_ALUOp), .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB), .RegWrite(n_RegWrite),
    .RegDst(n_RegDst), .illegal_op(n_illegal_op), .state_dbg(n_state_dbg)
  );

  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst};
  assign ctl_nw = {n_PCWrite, n_PCWriteCond, n_IorD, n_MemRead, n_MemWrite, n_MemtoReg,
                   n_IRWrite, n_PCSource, n_ALUOp, n_ALUSrcA, n_ALUSrcB, n_RegWrite, n_RegDst};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'd0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (ctl !== 16'h0 || state_dbg !== 4'd0 || illegal_op !== 1'b0) begin
        n_err++;
        $display("FAIL reset[%0d] ctl=%h st=%0d ill=%b want ctl=0000 st=0 ill=0",
                 i, ctl, state_dbg, illegal_op);
      end
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (state_dbg !== 4'd0 || ctl !== C_FETCH || n_state_dbg !== 4'd0) begin
      n_err++;
      $display("FAIL reset_release st=%0d ctl=%h nw_st=%0d want st=0 ctl=%h nw_st=0",
               state_dbg, ctl, n_state_dbg, C_FETCH);
    end
  endtask

  task automatic test_rtype();
    logic [3:0]  es[4];
    logic [15:0] ec[4];
    es = '{4'd0, 4'd1, 4'd6, 4'd7};
    ec = '{C_FETCH, C_DECODE, C_REXEC, C_RWB};
    opcode = 6'b000000; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (state_dbg !== es[i] || ctl !== ec[i]) begin
        n_err++;
        $display("FAIL rtype[%0d] st=%0d ctl=%h want st=%0d ctl=%h", i, state_dbg, ctl, es[i], ec[i]);
      end
      tick();
    end
    n_cmp++;
    if (state_dbg !== 4'd0) begin
      n_err++;
      $display("FAIL rtype_latency st=%0d want 0", state_dbg);
    end
  endtask

  task automatic test_lw_stall();
    logic [3:0]  es[8];
    logic [15:0] ec[8];
    logic        rd[8];
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    ec = '{C_FETCH, C_DECODE, C_MADDR, C_MREAD, C_MREAD, C_MREAD, C_MREAD, C_MWB};
    rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = 6'b100011;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rd[i];
      #1;
      n_cmp++;
      if (state_dbg !== es[i] || ctl !== ec[i]) begin
        n_err++;
        $display("FAIL lw_stall[%0d] st=%0d ctl=%h want st=%0d ctl=%h", i, state_dbg, ctl, es[i], ec[i]);
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (state_dbg !== 4'd0) begin
      n_err++;
      $display("FAIL lw_latency st=%0d want 0", state_dbg);
    end
  endtask

  task automatic test_beq_j();
    logic [3:0]  es[6];
    logic [15:0] ec[6];
    logic [5:0]  op[6];
    es = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9};
    ec = '{C_FETCH, C_DECODE, C_BRANCH, C_FETCH, C_DECODE, C_JUMP};
    op = '{6'b000100, 6'b000100, 6'b000100, 6'b000010, 6'b000010, 6'b000010};
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      opcode = op[i];
      #1;
      n_cmp++;
      if (state_dbg !== es[i] || ctl !== ec[i]) begin
        n_err++;
        $display("FAIL beq_j[%0d] st=%0d ctl=%h want st=%0d ctl=%h", i, state_dbg, ctl, es[i], ec[i]);
      end
      tick();
    end
    n_cmp++;
    if (state_dbg !== 4'd0) begin
      n_err++;
      $display("FAIL j_latency st=%0d want 0", state_dbg);
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  es[5];
    logic [15:0] ec[5];
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    ec = '{C_FETCH, C_DECODE, C_MADDR, C_MREAD, C_MWB};
    mem_ready = 1'b1;
    opcode = 6'b111111;
    #1;
    n_cmp++;
    if (illegal_op !== 1'b0 || state_dbg !== 4'd0) begin
      n_err++;
      $display("FAIL illegal_pre ill=%b st=%0d want ill=0 st=0", illegal_op, state_dbg);
    end
    tick();
    n_cmp++;
    if (state_dbg !== 4'd1 || ctl !== C_DECODE) begin
      n_err++;
      $display("FAIL illegal_decode st=%0d ctl=%h want st=1 ctl=%h", state_dbg, ctl, C_DECODE);
    end
    tick();
    n_cmp++;
    if (state_dbg !== 4'd0 || illegal_op !== 1'b1) begin
      n_err++;
      $display("FAIL illegal_set st=%0d ill=%b want st=0 ill=1", state_dbg, illegal_op);
    end
    opcode = 6'b100011;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (state_dbg !== es[i] || ctl !== ec[i] || illegal_op !== 1'b1) begin
        n_err++;
        $display("FAIL illegal_sticky[%0d] st=%0d ctl=%h ill=%b want st=%0d ctl=%h ill=1",
                 i, state_dbg, ctl, illegal_op, es[i], ec[i]);
      end
      tick();
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (illegal_op !== 1'b0 || ctl !== 16'h0) begin
      n_err++;
      $display("FAIL illegal_rst ill=%b ctl=%h want ill=0 ctl=0000", illegal_op, ctl);
    end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (illegal_op !== 1'b0 || state_dbg !== 4'd0) begin
      n_err++;
      $display("FAIL illegal_clear ill=%b st=%0d want ill=0 st=0", illegal_op, state_dbg);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [3:0]  es[5];
    logic [15:0] ec[5];
    logic        rd[5];
    es = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
    ec = '{C_FETCH, C_DECODE, C_MADDR, C_MWRITE, C_MWRITE};
    rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    opcode = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rd[i];
      #1;
      n_cmp++;
      if (state_dbg !== es[i] || ctl !== ec[i]) begin
        n_err++;
        $display("FAIL sw_wait[%0d] st=%0d ctl=%h want st=%0d ctl=%h", i, state_dbg, ctl, es[i], ec[i]);
      end
      tick();
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (MemWrite !== 1'b0 || RegWrite !== 1'b0 || ctl !== 16'h0 || state_dbg !== 4'd0) begin
      n_err++;
      $display("FAIL rst_mid_write MemWrite=%b RegWrite=%b ctl=%h st=%0d want 0 0 0000 0",
               MemWrite, RegWrite, ctl, state_dbg);
    end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (state_dbg !== 4'd0 || ctl !== C_FETCH_W) begin
      n_err++;
      $display("FAIL post_rst st=%0d ctl=%h want st=0 ctl=%h", state_dbg, ctl, C_FETCH_W);
    end
  endtask

  task automatic test_no_wait();
    logic [3:0]  es[4];
    logic [15:0] ec[4];
    es = '{4'd0, 4'd1, 4'd2, 4'd5};
    ec = '{C_FETCH, C_DECODE, C_MADDR, C_MWRITE};
    opcode = 6'b101011; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (n_state_dbg !== es[i] || ctl_nw !== ec[i]) begin
        n_err++;
        $display("FAIL nowait_sw[%0d] st=%0d ctl=%h want st=%0d ctl=%h", i, n_state_dbg, ctl_nw, es[i], ec[i]);
      end
      tick();
    end
    n_cmp++;
    if (n_state_dbg !== 4'd0 || state_dbg !== 4'd0 || ctl !== C_FETCH_W) begin
      n_err++;
      $display("FAIL nowait_latency nw_st=%0d st=%0d ctl=%h want 0 0 %h",
               n_state_dbg, state_dbg, ctl, C_FETCH_W);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_beq_j();
    test_illegal();
    test_reset_mid_write();
    test_no_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multi-cycle MIPS-subset datapath. It sequences instruction fetch, decode, execute, memory and write-back over several cycles, sharing one ALU and one unified memory port. Each cycle it drives the datapath mux/enable signals and the 2-bit ALUOp consumed by ALU_Control (00 = add, 01 = sub, 10 = decode funct). It stalls on a memory-ready handshake.

Parameters:
MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = treat memory as always ready (mem_ready ignored)
STATE_W, 4, width of the state register and of the state_dbg port

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
opcode  input  6  instruction[31:26] from the IR
mem_ready  input  1  memory has completed the current access this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU zero (beq)
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
MemtoReg  output  1  register write data: 0 = ALUOut, 1 = MDR
IRWrite  output  1  instruction register load
PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
ALUOp  output  2  to ALU_Control: 00 add, 01 sub, 10 funct
ALUSrcA  output  1  0 = PC, 1 = rs register (A)
ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
RegWrite  output  1  register file write enable
RegDst  output  1  write register select: 0 = rt, 1 = rd
illegal_op  output  1  sticky flag: an unsupported opcode was decoded
state_dbg  output  STATE_W  current state encoding

Behaviour:
- Reset: when rst is sampled high, the next state is FETCH and illegal_op clears to 0. While rst is high, every control output is forced to 0 and state_dbg reads FETCH.
- Outputs are Moore-decoded from the state register. Exception: the stall-qualified signals below are ANDed with the effective ready signal. Effective ready = mem_ready when MEM_WAIT_EN = 1, otherwise 1.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010.
- Unlisted outputs are 0 in each state.
- FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite are 1 only when ready.
  - Stays in FETCH until ready, then goes to DECODE.
- DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes branch target). Next state:
  - lw/sw -> MEM_ADDR
  - R-type -> R_EXEC
  - beq -> BRANCH
  - j -> JUMP
  - any other opcode -> FETCH, and illegal_op is set (it stays set until reset).
- MEM_ADDR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ (3): MemRead=1, IorD=1. Waits for ready, then goes to MEM_WB.
- MEM_WB (4): RegWrite=1, MemtoReg=1, RegDst=0. Next: FETCH.
- MEM_WRITE (5): MemWrite=1, IorD=1. Waits for ready, then goes to FETCH. MemWrite stays high throughout the wait.
- R_EXEC (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: R_WB.
- R_WB (7): RegWrite=1, RegDst=1, MemtoReg=0. Next: FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next: FETCH.
- JUMP (9): PCWrite=1, PCSource=10. Next: FETCH.
- Encodings 10-15 are unreachable. If ever entered, the FSM goes to FETCH on the next cycle with all outputs 0.
- opcode is sampled only in DECODE and MEM_ADDR; the IR holds it stable from the end of FETCH onward.
- Zero-wait latencies: j 3 cycles, beq 3, R-type 4, sw 4, lw 5. Each wait cycle on mem_ready adds one cycle.
- Reset in mid-instruction takes priority over every transition and output. No partial write is retained: RegWrite and MemWrite are 0 during the reset cycle.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state localparams (S_FETCH..S_JUMP)
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J)
  - ALUOp constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10)
  - ALUSrcB and PCSource selector constants
- The package is reused by ALU_Control and the datapath.
- Sub-module mc_next_state holds the combinational next-state function. The output decode stays in the top module alongside the state register.

Test Plan:
- rst=1 for 2 cycles, then released, mem_ready=1 -> all outputs 0 during reset; first cycle after release: state_dbg=0, MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- opcode=000000, mem_ready=1 -> states 0,1,6,7,0. In state 6 ALUOp=10. In state 7 RegWrite=1, RegDst=1. 4 cycles total.
- opcode=100011, mem_ready low for 3 cycles in MEM_READ -> states 0,1,2,3,3,3,3,4,0. MemRead and IorD held at 1 throughout state 3. RegWrite=1, MemtoReg=1 in state 4.
- opcode=000100 then opcode=000010 -> beq: states 0,1,8 with ALUOp=01, PCWriteCond=1, PCSource=01. j: states 0,1,9 with PCWrite=1, PCSource=10.
- opcode=111111 -> DECODE returns to FETCH; illegal_op=1 and stays 1 through a following valid lw; cleared only by rst.
- rst asserted during MEM_WRITE with mem_ready=0 -> MemWrite=0 in the reset cycle; state_dbg=0 after reset. With MEM_WAIT_EN=0 and mem_ready tied 0, sw still completes in 4 cycles.
